or_event_latch: RTL and testbench
=================================

# or_event_latch

Parametrised, sequential successor to the plain 16-bit OR-reduce used for game-event detection (collisions, hits, button flags).
- Reduces `WIDTH` request lines to a registered `any` flag.
- Latches every request into a sticky pending register.
- Presents the lowest-numbered pending event with its index and the pending count.
- Lets the game FSM consume events one at a time with `ack`, or flush them all with `clr_all`.

## Interface
- `WIDTH`, 16: number of request lines; 2..32.
- `IDX_W`, 4: index width; must equal ceil(log2(`WIDTH`)).
- `EDGE`, 1: 1 = capture rising edges of `in`; 0 = capture while `in` bit is high (level).
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in` in `WIDTH`: request lines, synchronous to `clk`.
- `ack` in 1: consume the event currently shown on `idx`.
- `clr_all` in 1: clear all pending events.
- `any` out 1: registered OR of all `in` bits.
- `pending` out `WIDTH`: sticky pending-event register.
- `valid` out 1: at least one pending bit set.
- `idx` out `IDX_W`: index of the lowest set pending bit; 0 when `valid`=0.
- `count` out `IDX_W+1`: number of set pending bits (0..`WIDTH`).

## Operation
- State registers:
  - `in_q`: previous `in`.
  - `any`.
  - `pending`.
- Capture vector:
  - `set = in & ~in_q` when `EDGE`=1.
  - `set = in` when `EDGE`=0.
- Clear vector: `clr = one-hot(idx)` when `ack` && `valid`, else 0.
- `ack` while `valid`=0 is ignored; no state change.
- Next-state priority, evaluated per edge:
  1. `clr_all`=1: `pending` <= 0. Any `set` in the same cycle is dropped.
  2. Otherwise: `pending` <= (`pending` & ~`clr`) | `set`.
  3. A bit that is both acked and newly set in the same cycle stays 1; set wins over ack.
- Every edge:
  - `in_q` <= `in`.
  - `any` <= |`in`.
- `valid`, `idx` and `count` are combinational functions of the `pending` register only. They never depend directly on `in`, `ack` or `clr_all`.
  - `idx`: fixed priority, bit 0 highest.
  - `count`: population count, full width, no saturation needed (max `WIDTH` fits `IDX_W+1` bits).
- Reset (async assert, released synchronously by the integrator), all zero:
  - `in_q`, `any`, `pending` = 0.
  - Therefore `valid`=0, `idx`=0, `count`=0.
- First edge after reset in EDGE mode: because `in_q`=0, a line already high is captured as a rising edge.
- Reset asserted mid-operation: all pending events are lost immediately. There is no queued state anywhere else.

## Timing
- `in` sampled at edge N:
  - `pending` bit, `valid`, `idx`, `count` reflect it after edge N (1-cycle latency).
  - `any` reflects the same sample after edge N.
- `ack` sampled at edge N clears `pending[idx]`. `idx` and `valid` show the next event after edge N.
- Back-to-back `ack` on consecutive cycles drains one event per cycle. Draining K events takes K cycles.
- EDGE=1, line held high: captured exactly once. It is re-captured only after at least one low cycle followed by a high.
- EDGE=0, line held high: the bit re-sets every cycle, so `ack` cannot clear it until the line drops. `clr_all` does clear it for one cycle; it re-sets on the next edge if the line is still high.
- All outputs are glitch-free with respect to `in`; outputs derive only from registers.

## Test plan
- Reset release, `in`=0: `any`=0, `pending`=0, `valid`=0, `idx`=0, `count`=0. Assert `rst` mid-run with `pending`=16'h00F0: all outputs return to 0 asynchronously, before the next clock edge.
- EDGE=1:
  - Pulse `in`=16'h0024 for 1 cycle: `pending`=16'h0024, `count`=2, `idx`=2.
  - `ack`: `idx`=5, `count`=1.
  - `ack`: `valid`=0.
- EDGE=1, hold `in[3]` high for 10 cycles: one capture only. Single `ack` gives `pending`=0 while the line is still high.
- Simultaneous events, `pending`=16'h0001:
  - Same cycle: `ack`=1 and `in` rises on bit 0 → `pending` stays 16'h0001.
  - Same cycle: `clr_all`=1 and `in` rises on bit 7 → `pending`=0.
- EDGE=0, `in[15]` high for 3 cycles with `ack` each cycle → `pending[15]` stays 1. Drop `in[15]`, then one `ack` → `pending`=0.
- `in`=16'hFFFF pulse with `WIDTH`=16: `count`=16 (5'b10000) and `any`=1. Then 16 consecutive `ack`s drain `idx` 0..15 in order, ending at `valid`=0.

Source files
------------

// File: rtl/or_event_latch.sv
// Sticky event latch: registers the OR of the request lines, accumulates requests into
// a pending register and presents the lowest pending event for one-at-a-time consumption.
module or_event_latch #(
   parameter int WIDTH = 16,
   parameter int IDX_W = 4,
   parameter bit EDGE  = 1'b1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [WIDTH-1:0]   in_i,
   input  logic               ack_i,
   input  logic               clr_all_i,
   output logic               any_o,
   output logic [WIDTH-1:0]   pending_o,
   output logic               valid_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic [IDX_W:0]     count_o
);

   logic [WIDTH-1:0] in_q;
   logic [WIDTH-1:0] pending_q, pending_d;
   logic             any_q, any_d;
   logic [WIDTH-1:0] set_v;
   logic [WIDTH-1:0] clr_v;
   logic             valid_v;
   logic [IDX_W-1:0] idx_v;
   logic [IDX_W:0]   count_v;

   // Status is derived from pending_q only, so outputs never glitch with the inputs.
   always_comb begin
      valid_v = |pending_q;
      idx_v   = '0;
      count_v = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            idx_v = IDX_W'(i);
         end
      end
      for (int i = 0; i < WIDTH; i++) begin
         count_v = count_v + (IDX_W + 1)'(pending_q[i]);
      end
   end

   always_comb begin
      set_v = EDGE ? (in_i & ~in_q) : in_i;
      clr_v = '0;
      if (ack_i && valid_v) begin
         clr_v[idx_v] = 1'b1;
      end
      any_d = |in_i;
      // A bit acked and newly set in the same cycle stays set.
      if (clr_all_i) begin
         pending_d = '0;
      end else begin
         pending_d = (pending_q & ~clr_v) | set_v;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         in_q      <= '0;
         any_q     <= 1'b0;
         pending_q <= '0;
      end else begin
         in_q      <= in_i;
         any_q     <= any_d;
         pending_q <= pending_d;
      end
   end

   assign any_o     = any_q;
   assign pending_o = pending_q;
   assign valid_o   = valid_v;
   assign idx_o     = idx_v;
   assign count_o   = count_v;

endmodule

// File: tb/tb_or_event_latch.sv
// Directed bench for or_event_latch: one edge-mode and one level-mode instance.
module tb_or_event_latch;

   logic        clk;
   logic        rst;
   logic [15:0] in_a, in_b;
   logic        ack_a, ack_b, clr_a, clr_b;
   logic        any_a, any_b, valid_a, valid_b;
   logic [15:0] pend_a, pend_b;
   logic [3:0]  idx_a, idx_b;
   logic [4:0]  cnt_a, cnt_b;

   int checks = 0;
   int errors = 0;

   or_event_latch #(.WIDTH(16), .IDX_W(4), .EDGE(1'b1)) dut_edge (
      .clk_i(clk), .rst_i(rst), .in_i(in_a), .ack_i(ack_a), .clr_all_i(clr_a),
      .any_o(any_a), .pending_o(pend_a), .valid_o(valid_a), .idx_o(idx_a), .count_o(cnt_a)
   );

   or_event_latch #(.WIDTH(16), .IDX_W(4), .EDGE(1'b0)) dut_level (
      .clk_i(clk), .rst_i(rst), .in_i(in_b), .ack_i(ack_b), .clr_all_i(clr_b),
      .any_o(any_b), .pending_o(pend_b), .valid_o(valid_b), .idx_o(idx_b), .count_o(cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      in_a = '0; in_b = '0;
      ack_a = 0; ack_b = 0; clr_a = 0; clr_b = 0;
      step(); step();
      rst = 1'b0;
      step();
      check("rst_any", 32'(any_a), 32'h0);
      check("rst_pending", 32'(pend_a), 32'h0);
      check("rst_valid", 32'(valid_a), 32'h0);
      check("rst_idx", 32'(idx_a), 32'h0);
      check("rst_count", 32'(cnt_a), 32'h0);

      // Two-bit pulse then drain
      in_a = 16'h0024;
      step();
      check("pulse_pending", 32'(pend_a), 32'h0024);
      check("pulse_count", 32'(cnt_a), 32'd2);
      check("pulse_idx", 32'(idx_a), 32'd2);
      check("pulse_any", 32'(any_a), 32'h1);
      in_a = '0; ack_a = 1;
      step();
      check("ack1_idx", 32'(idx_a), 32'd5);
      check("ack1_count", 32'(cnt_a), 32'd1);
      check("ack1_any", 32'(any_a), 32'h0);
      step();
      check("ack2_valid", 32'(valid_a), 32'h0);
      check("ack2_pending", 32'(pend_a), 32'h0);
      ack_a = 0;

      // Held line captured once; single ack clears it while still high
      in_a = 16'h0008;
      step();
      check("hold_first", 32'(pend_a), 32'h0008);
      for (int i = 0; i < 8; i++) begin
         step();
         check("hold_once", 32'(pend_a), 32'h0008);
      end
      ack_a = 1;
      step();
      check("hold_ack", 32'(pend_a), 32'h0);
      check("hold_ack_count", 32'(cnt_a), 32'h0);
      ack_a = 0; in_a = '0;
      step();

      // Set wins over ack; clr_all wins over set
      in_a = 16'h0001;
      step();
      check("sim_setup", 32'(pend_a), 32'h0001);
      in_a = '0;
      step();
      ack_a = 1; in_a = 16'h0001;
      step();
      check("set_over_ack", 32'(pend_a), 32'h0001);
      ack_a = 0; in_a = '0;
      step();
      check("sim_keep", 32'(pend_a), 32'h0001);
      clr_a = 1; in_a = 16'h0080;
      step();
      check("clrall_over_set", 32'(pend_a), 32'h0);
      clr_a = 0; in_a = '0;
      step();
      check("clrall_after", 32'(pend_a), 32'h0);

      // Asynchronous reset mid-run
      in_a = 16'h00F0;
      step();
      check("pre_rst_pending", 32'(pend_a), 32'h00F0);
      in_a = '0;
      #2 rst = 1'b1;
      #1;
      check("async_rst_pending", 32'(pend_a), 32'h0);
      check("async_rst_valid", 32'(valid_a), 32'h0);
      check("async_rst_count", 32'(cnt_a), 32'h0);
      check("async_rst_idx", 32'(idx_a), 32'h0);
      #1 rst = 1'b0;

      // Full-width pulse then 16 back-to-back acks
      in_a = 16'hFFFF;
      step();
      check("full_count", 32'(cnt_a), 32'd16);
      check("full_any", 32'(any_a), 32'h1);
      check("full_pending", 32'(pend_a), 32'hFFFF);
      in_a = '0; ack_a = 1;
      for (int i = 0; i < 16; i++) begin
         check("drain_idx", 32'(idx_a), 32'(i));
         check("drain_count", 32'(cnt_a), 32'(16 - i));
         step();
      end
      check("drain_valid", 32'(valid_a), 32'h0);
      check("drain_count_end", 32'(cnt_a), 32'h0);
      ack_a = 0;

      // Level mode: held line survives ack, clears after drop
      in_b = 16'h8000; ack_b = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("level_hold", 32'(pend_b), 32'h8000);
         check("level_idx", 32'(idx_b), 32'd15);
      end
      in_b = '0; ack_b = 0;
      step();
      check("level_drop", 32'(pend_b), 32'h8000);
      check("level_any", 32'(any_b), 32'h0);
      ack_b = 1;
      step();
      check("level_ack", 32'(pend_b), 32'h0);
      ack_b = 0;
      in_b = 16'h0004;
      step();
      check("level_set", 32'(pend_b), 32'h0004);
      clr_b = 1;
      step();
      check("level_clrall", 32'(pend_b), 32'h0);
      clr_b = 0;
      step();
      check("level_reset_again", 32'(pend_b), 32'h0004);
      in_b = '0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
